// File: rtl/seed_pkg.sv
// Shared SEED constants: S-boxes, G-function masks and datapath width legality.
package seed_pkg;

  localparam logic [7:0] S1 [256] = '{
    8'hA9, 8'h85, 8'hD6, 8'hD3, 8'h54, 8'h1D, 8'hAC, 8'h25, 8'h5D, 8'h43, 8'h18, 8'h1E, 8'h51, 8'hFC, 8'hCA, 8'h63,
    8'h28, 8'h44, 8'h20, 8'h9D, 8'hE0, 8'hE2, 8'hC8, 8'h17, 8'hA5, 8'h8F, 8'h03, 8'h7B, 8'hBB, 8'h13, 8'hD2, 8'hEE,
    8'h70, 8'h8C, 8'h3F, 8'hA8, 8'h32, 8'hDD, 8'hF6, 8'h74, 8'hEC, 8'h95, 8'h0B, 8'h57, 8'h5C, 8'h5B, 8'hBD, 8'h01,
    8'h24, 8'h1C, 8'h73, 8'h98, 8'h10, 8'hCC, 8'hF2, 8'hD9, 8'h2C, 8'hE7, 8'h72, 8'h83, 8'h9B, 8'hD1, 8'h86, 8'hC9,
    8'h60, 8'h50, 8'hA3, 8'hEB, 8'h0D, 8'hB6, 8'h9E, 8'h4F, 8'hB7, 8'h5A, 8'hC6, 8'h78, 8'hA6, 8'h12, 8'hAF, 8'hD5,
    8'h61, 8'hC3, 8'hB4, 8'h41, 8'h52, 8'h7D, 8'h8D, 8'h08, 8'h1F, 8'h99, 8'h00, 8'h19, 8'h04, 8'h53, 8'hF7, 8'hE1,
    8'hFD, 8'h76, 8'h2F, 8'h27, 8'hB0, 8'h8B, 8'h0E, 8'hAB, 8'hA2, 8'h6E, 8'h93, 8'h4D, 8'h69, 8'h7C, 8'h09, 8'h0A,
    8'hBF, 8'hEF, 8'hF3, 8'hC5, 8'h87, 8'h14, 8'hFE, 8'h64, 8'hDE, 8'h2E, 8'h4B, 8'h1A, 8'h06, 8'h21, 8'h6B, 8'h66,
    8'h02, 8'hF5, 8'h92, 8'h8A, 8'h0C, 8'hB3, 8'h7E, 8'hD0, 8'h7A, 8'h47, 8'h96, 8'hE5, 8'h26, 8'h80, 8'hAD, 8'hDF,
    8'hA1, 8'h30, 8'h37, 8'hAE, 8'h36, 8'h15, 8'h22, 8'h38, 8'hF4, 8'hA7, 8'h45, 8'h4C, 8'h81, 8'hE9, 8'h84, 8'h97,
    8'h35, 8'hCB, 8'hCE, 8'h3C, 8'h71, 8'h11, 8'hC7, 8'h89, 8'h75, 8'hFB, 8'hDA, 8'hF8, 8'h94, 8'h59, 8'h82, 8'hC4,
    8'hFF, 8'h49, 8'h39, 8'h67, 8'hC0, 8'hCF, 8'hD7, 8'hB8, 8'h0F, 8'h8E, 8'h42, 8'h23, 8'h91, 8'h6C, 8'hDB, 8'hA4,
    8'h34, 8'hF1, 8'h48, 8'hC2, 8'h6F, 8'h3D, 8'h2D, 8'h40, 8'hBE, 8'h3E, 8'hBC, 8'hC1, 8'hAA, 8'hBA, 8'h4E, 8'h55,
    8'h3B, 8'hDC, 8'h68, 8'h7F, 8'h9C, 8'hD8, 8'h4A, 8'h56, 8'h77, 8'hA0, 8'hED, 8'h46, 8'hB5, 8'h2B, 8'h65, 8'hFA,
    8'hE3, 8'hB9, 8'hB1, 8'h9F, 8'h5E, 8'hF9, 8'hE6, 8'hB2, 8'h31, 8'hEA, 8'h6D, 8'h5F, 8'hE4, 8'hF0, 8'hCD, 8'h88,
    8'h16, 8'h3A, 8'h58, 8'hD4, 8'h62, 8'h29, 8'h07, 8'h33, 8'hE8, 8'h1B, 8'h05, 8'h79, 8'h90, 8'h6A, 8'h2A, 8'h9A
  };

  localparam logic [7:0] S2 [256] = '{
    8'h38, 8'hE8, 8'h2D, 8'hA6, 8'hCF, 8'hDE, 8'hB3, 8'hB8, 8'hAF, 8'h60, 8'h55, 8'hC7, 8'h44, 8'h6F, 8'h6B, 8'h5B,
    8'hC3, 8'h62, 8'h33, 8'hB5, 8'h29, 8'hA0, 8'hE2, 8'hA7, 8'hD3, 8'h91, 8'h11, 8'h06, 8'h1C, 8'hBC, 8'h36, 8'h4B,
    8'hEF, 8'h88, 8'h6C, 8'hA8, 8'h17, 8'hC4, 8'h16, 8'hF4, 8'hC2, 8'h45, 8'hE1, 8'hD6, 8'h3F, 8'h3D, 8'h8E, 8'h98,
    8'h28, 8'h4E, 8'hF6, 8'h3E, 8'hA5, 8'hF9, 8'h0D, 8'hDF, 8'hD8, 8'h2B, 8'h66, 8'h7A, 8'h27, 8'h2F, 8'hF1, 8'h72,
    8'h42, 8'hD4, 8'h41, 8'hC0, 8'h73, 8'h67, 8'hAC, 8'h8B, 8'hF7, 8'hAD, 8'h80, 8'h1F, 8'hCA, 8'h2C, 8'hAA, 8'h34,
    8'hD2, 8'h0B, 8'hEE, 8'hE9, 8'h5D, 8'h94, 8'h18, 8'hF8, 8'h57, 8'hAE, 8'h08, 8'hC5, 8'h13, 8'hCD, 8'h86, 8'hB9,
    8'hFF, 8'h7D, 8'hC1, 8'h31, 8'hF5, 8'h8A, 8'h6A, 8'hB1, 8'hD1, 8'h20, 8'hD7, 8'h02, 8'h22, 8'h04, 8'h68, 8'h71,
    8'h07, 8'hDB, 8'h9D, 8'h99, 8'h61, 8'hBE, 8'hE6, 8'h59, 8'hDD, 8'h51, 8'h90, 8'hDC, 8'h9A, 8'hA3, 8'hAB, 8'hD0,
    8'h81, 8'h0F, 8'h47, 8'h1A, 8'hE3, 8'hEC, 8'h8D, 8'hBF, 8'h96, 8'h7B, 8'h5C, 8'hA2, 8'hA1, 8'h63, 8'h23, 8'h4D,
    8'hC8, 8'h9E, 8'h9C, 8'h3A, 8'h0C, 8'h2E, 8'hBA, 8'h6E, 8'h9F, 8'h5A, 8'hF2, 8'h92, 8'hF3, 8'h49, 8'h78, 8'hCC,
    8'h15, 8'hFB, 8'h70, 8'h75, 8'h7F, 8'h35, 8'h10, 8'h03, 8'h64, 8'h6D, 8'hC6, 8'h74, 8'hD5, 8'hB4, 8'hEA, 8'h09,
    8'h76, 8'h19, 8'hFE, 8'h40, 8'h12, 8'hE0, 8'hBD, 8'h05, 8'hFA, 8'h01, 8'hF0, 8'h2A, 8'h5E, 8'hA9, 8'h56, 8'h43,
    8'h85, 8'h14, 8'h89, 8'h9B, 8'hB0, 8'hE5, 8'h48, 8'h79, 8'h97, 8'hFC, 8'h1E, 8'h82, 8'h21, 8'h8C, 8'h1B, 8'h5F,
    8'h77, 8'h54, 8'hB2, 8'h1D, 8'h25, 8'h4F, 8'h00, 8'h46, 8'hED, 8'h58, 8'h52, 8'hEB, 8'h7E, 8'hDA, 8'hC9, 8'hFD,
    8'h30, 8'h95, 8'h65, 8'h3C, 8'hB6, 8'hE4, 8'hBB, 8'h7C, 8'h0E, 8'h50, 8'h39, 8'h26, 8'h32, 8'h84, 8'h69, 8'h93,
    8'h37, 8'hE7, 8'h24, 8'hA4, 8'hCB, 8'h53, 8'h0A, 8'h87, 8'hD9, 8'h4C, 8'h83, 8'h8F, 8'hCE, 8'h3B, 8'h4A, 8'hB7
  };

  localparam logic [7:0] G_MASK [4] = '{8'hFC, 8'hF3, 8'hCF, 8'h3F};

  function automatic bit lane_w_legal(input int unsigned w);
    return (w == 32'd8) || (w == 32'd16) || (w == 32'd32);
  endfunction

endpackage

// File: rtl/seed_g_core.sv
// Combinational SEED G function: S-box substitution followed by masked byte mixing.
module seed_g_core
  import seed_pkg::*;
(
  input  logic [31:0] x,
  output logic [31:0] z
);

  logic [3:0][7:0] y;

  // Even bytes go through S1, odd bytes through S2; Zi mixes every Yj under mask m[(i+j) mod 4]
  always_comb begin
    y = '0;
    z = '0;
    for (int j = 0; j < 4; j++) begin
      y[j] = (j % 2 == 0) ? S1[x[8*j +: 8]] : S2[x[8*j +: 8]];
    end
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        z[8*i +: 8] = z[8*i +: 8] ^ (y[j] & G_MASK[(i + j) % 4]);
      end
    end
  end

endmodule

// File: rtl/seed_g_stream.sv
// Streaming wrapper around the SEED G core: gathers LANE_W-bit beats into a word,
// transforms it on the last beat, and serialises the result with ready/valid backpressure.
module seed_g_stream
  import seed_pkg::*;
#(
  parameter int unsigned LANE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [LANE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              resync,
  output logic [LANE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_first
);

  localparam int unsigned LANES     = LANE_W / 8;
  localparam int unsigned BEATS     = 4 / LANES;
  localparam int unsigned CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST    = CW'(BEATS - 1);
  localparam logic [31:0] LANE_MASK = 32'((64'd1 << LANE_W) - 64'd1);

  if (!lane_w_legal(LANE_W)) begin : g_bad_lane_w
    $fatal(1, "seed_g_stream: LANE_W must be 8, 16 or 32");
  end

  logic [CW-1:0] in_cnt;
  logic [CW-1:0] eff_cnt;
  logic [CW-1:0] out_cnt;
  logic [CW-1:0] out_nxt;
  logic [31:0]   in_reg;
  logic [31:0]   res_reg;
  logic [31:0]   word_c;
  logic [31:0]   z_c;
  logic [5:0]    in_sh;
  logic [5:0]    out_sh;
  logic          accept;
  logic          in_last;
  logic          out_fire;
  logic          out_last;
  logic          res_free;

  // A last input beat may only land if the result register is empty or being emptied now
  always_comb begin
    eff_cnt  = resync ? '0 : in_cnt;
    in_last  = (eff_cnt == LAST);
    out_last = (out_cnt == LAST);
    out_fire = out_valid & out_ready;
    res_free = !out_valid | (out_fire & out_last);
    in_ready = !in_last | res_free;
    accept   = in_valid & in_ready;
    in_sh    = 6'(eff_cnt) * 6'(LANE_W);
    word_c   = (in_reg & ~(LANE_MASK << in_sh)) | (32'(in_data) << in_sh);
    out_nxt  = out_last ? '0 : out_cnt + 1'b1;
    out_sh   = 6'(out_nxt) * 6'(LANE_W);
  end

  seed_g_core u_core (
    .x(word_c),
    .z(z_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt    <= '0;
      in_reg    <= '0;
      res_reg   <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
    end else begin
      if (accept) begin
        in_reg <= word_c;
        in_cnt <= in_last ? '0 : eff_cnt + 1'b1;
      end else if (resync) begin
        in_cnt <= '0;
      end

      // A fresh result always wins: it can only arrive when the old one is done
      if (accept && in_last) begin
        res_reg   <= z_c;
        out_valid <= 1'b1;
        out_cnt   <= '0;
        out_first <= 1'b1;
        out_data  <= z_c[LANE_W-1:0];
      end else if (out_fire) begin
        out_cnt   <= out_nxt;
        out_first <= 1'b0;
        if (out_last) begin
          out_valid <= 1'b0;
        end else begin
          out_data <= LANE_W'(res_reg >> out_sh);
        end
      end
    end
  end

endmodule
